// File: rtl/alu_pkg.sv
// Shared encodings for the ALU sequencer: command codes, ALU opcodes, FSM states
// and NZCV bit positions.
package alu_pkg;

   localparam logic [3:0] CMD_ADD   = 4'd0;
   localparam logic [3:0] CMD_SUB   = 4'd1;
   localparam logic [3:0] CMD_ADC   = 4'd2;
   localparam logic [3:0] CMD_SBC   = 4'd3;
   localparam logic [3:0] CMD_AND   = 4'd4;
   localparam logic [3:0] CMD_ORR   = 4'd5;
   localparam logic [3:0] CMD_EOR   = 4'd6;
   localparam logic [3:0] CMD_ADD64 = 4'd7;
   localparam logic [3:0] CMD_SUB64 = 4'd8;

   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_AND = 4'b0001;
   localparam logic [3:0] OP_ORR = 4'b0011;
   localparam logic [3:0] OP_EOR = 4'b0101;
   localparam logic [3:0] OP_ADD = 4'b0111;
   localparam logic [3:0] OP_SUB = 4'b1000;
   localparam logic [3:0] OP_ADC = 4'b1001;
   localparam logic [3:0] OP_SBC = 4'b1010;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXEC_LO = 2'd1,
      ST_EXEC_HI = 2'd2,
      ST_RESP    = 2'd3
   } state_t;

   localparam int FL_N = 3;
   localparam int FL_Z = 2;
   localparam int FL_C = 1;
   localparam int FL_V = 0;

   function automatic logic cmd_legal(input logic [3:0] cmd);
      return cmd <= CMD_SUB64;
   endfunction

   function automatic logic cmd_logical(input logic [3:0] cmd);
      return (cmd == CMD_AND) || (cmd == CMD_ORR) || (cmd == CMD_EOR);
   endfunction

   function automatic logic cmd_wide(input logic [3:0] cmd);
      return (cmd == CMD_ADD64) || (cmd == CMD_SUB64);
   endfunction

endpackage

// File: rtl/alu_seq_ctrl_alu.sv
// 32-bit combinational ALU with MSB-first vectors. For SUB/SBC the carry in and
// carry out are borrows, so subtract chains propagate borrow directly.
module ALU
   import alu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [0:31] a,
   input  logic [0:31] b,
   input  logic        ci,
   output logic [0:31] y,
   output logic        n,
   output logic        z,
   output logic        c,
   output logic        v
);

   logic [32:0] ext;

   always_comb begin
      ext = '0;
      y   = '0;
      c   = 1'b0;
      v   = 1'b0;
      case (op)
         OP_ADD, OP_ADC: begin
            ext = {1'b0, a} + {1'b0, b} + {32'd0, (op == OP_ADC) & ci};
            y   = ext[31:0];
            c   = ext[32];
            v   = (a[0] == b[0]) && (y[0] != a[0]);
         end
         OP_SUB, OP_SBC: begin
            // Bit 32 of the 33-bit wrap-around difference is the borrow out.
            ext = {1'b0, a} - {1'b0, b} - {32'd0, (op == OP_SBC) & ci};
            y   = ext[31:0];
            c   = ext[32];
            v   = (a[0] != b[0]) && (y[0] != a[0]);
         end
         OP_AND: y = a & b;
         OP_ORR: y = a | b;
         OP_EOR: y = a ^ b;
         default: y = '0;
      endcase
      n = y[0];
      z = ~|y;
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer for the 32-bit ALU: one pass for 32-bit commands, two chained
// passes for ADD64/SUB64, and owner of the architectural NZCV register.
module alu_seq_ctrl
   import alu_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_cmd,
   input  logic [63:0]      req_a,
   input  logic [63:0]      req_b,
   input  logic             req_setflags,
   input  logic [TAG_W-1:0] req_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [63:0]      rsp_y,
   output logic [3:0]       rsp_flags,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_illegal,
   output logic [3:0]       flags_q
);

   state_t           state, state_nx;
   logic [3:0]       cmd_r;
   logic [63:0]      a_r, b_r;
   logic             sf_r;
   logic [TAG_W-1:0] tag_r;
   logic             lo_co, lo_z;

   logic [3:0]  alu_op;
   logic [31:0] alu_a, alu_b, alu_y;
   logic        alu_ci, alu_n, alu_z, alu_c, alu_v;
   logic [3:0]  pass_flags;
   logic        accept;

   function automatic logic [3:0] cmd_op(input logic [3:0] cmd);
      case (cmd)
         CMD_ADD, CMD_ADD64: return OP_ADD;
         CMD_SUB, CMD_SUB64: return OP_SUB;
         CMD_ADC:            return OP_ADC;
         CMD_SBC:            return OP_SBC;
         CMD_AND:            return OP_AND;
         CMD_ORR:            return OP_ORR;
         CMD_EOR:            return OP_EOR;
         default:            return OP_NOP;
      endcase
   endfunction

   ALU u_alu (
      .op (alu_op),
      .a  (alu_a),
      .b  (alu_b),
      .ci (alu_ci),
      .y  (alu_y),
      .n  (alu_n),
      .z  (alu_z),
      .c  (alu_c),
      .v  (alu_v)
   );

   assign accept    = req_valid && req_ready;
   assign rsp_valid = (state == ST_RESP);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:    if (accept) state_nx = cmd_legal(req_cmd) ? ST_EXEC_LO : ST_RESP;
         ST_EXEC_LO: state_nx = cmd_wide(cmd_r) ? ST_EXEC_HI : ST_RESP;
         ST_EXEC_HI: state_nx = ST_RESP;
         ST_RESP:    if (rsp_ready) state_nx = ST_IDLE;
         default:    state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == ST_IDLE);
      alu_op    = OP_NOP;
      alu_a     = '0;
      alu_b     = '0;
      alu_ci    = 1'b0;
      case (state)
         ST_EXEC_LO: begin
            alu_op = cmd_op(cmd_r);
            alu_a  = a_r[31:0];
            alu_b  = b_r[31:0];
            alu_ci = ((cmd_r == CMD_ADC) || (cmd_r == CMD_SBC)) & flags_q[FL_C];
         end
         ST_EXEC_HI: begin
            alu_op = (cmd_r == CMD_SUB64) ? OP_SBC : OP_ADC;
            alu_a  = a_r[63:32];
            alu_b  = b_r[63:32];
            alu_ci = lo_co;
         end
         default: ;
      endcase
      pass_flags[FL_N] = alu_n;
      pass_flags[FL_Z] = (state == ST_EXEC_HI) ? (lo_z & alu_z) : alu_z;
      pass_flags[FL_C] = cmd_logical(cmd_r) ? flags_q[FL_C] : alu_c;
      pass_flags[FL_V] = cmd_logical(cmd_r) ? flags_q[FL_V] : alu_v;
   end

   // Logical commands already carry the held C/V in pass_flags, so committing the
   // whole nibble only changes N and Z for them.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_r       <= '0;
         a_r         <= '0;
         b_r         <= '0;
         sf_r        <= 1'b0;
         tag_r       <= '0;
         lo_co       <= 1'b0;
         lo_z        <= 1'b0;
         rsp_y       <= '0;
         rsp_flags   <= '0;
         rsp_tag     <= '0;
         rsp_illegal <= 1'b0;
         flags_q     <= '0;
      end else begin
         case (state)
            ST_IDLE: if (accept) begin
               cmd_r <= req_cmd;
               a_r   <= req_a;
               b_r   <= req_b;
               sf_r  <= req_setflags;
               tag_r <= req_tag;
               if (!cmd_legal(req_cmd)) begin
                  rsp_y       <= '0;
                  rsp_flags   <= '0;
                  rsp_tag     <= req_tag;
                  rsp_illegal <= 1'b1;
               end
            end
            ST_EXEC_LO: begin
               rsp_y[31:0] <= alu_y;
               lo_co       <= alu_c;
               lo_z        <= alu_z;
               if (!cmd_wide(cmd_r)) begin
                  rsp_y[63:32] <= '0;
                  rsp_flags    <= pass_flags;
                  rsp_tag      <= tag_r;
                  rsp_illegal  <= 1'b0;
                  if (sf_r) flags_q <= pass_flags;
               end
            end
            ST_EXEC_HI: begin
               rsp_y[63:32] <= alu_y;
               rsp_flags    <= pass_flags;
               rsp_tag      <= tag_r;
               rsp_illegal  <= 1'b0;
               if (sf_r) flags_q <= pass_flags;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed and random checks of alu_seq_ctrl against a whole-word arithmetic model.
module tb_alu_seq_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid, req_ready;
   logic [3:0]  req_cmd;
   logic [63:0] req_a, req_b;
   logic        req_setflags;
   logic [3:0]  req_tag;
   logic        rsp_valid, rsp_ready;
   logic [63:0] rsp_y;
   logic [3:0]  rsp_flags;
   logic [3:0]  rsp_tag;
   logic        rsp_illegal;
   logic [3:0]  flags_q;

   int          checks = 0;
   int          errors = 0;
   logic [3:0]  exp_fq;
   logic [63:0] last_y;
   logic [3:0]  last_f;

   alu_seq_ctrl #(.TAG_W(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
      .req_a(req_a), .req_b(req_b), .req_setflags(req_setflags), .req_tag(req_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
      .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal),
      .flags_q(flags_q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
      end
   endtask

   // Reference: whole-word arithmetic, flags {N,Z,C,V}; C is a borrow for subtracts.
   function automatic void ref_model(input logic [3:0] cmd, input logic [63:0] a,
                                     input logic [63:0] b, input logic [3:0] fq,
                                     output logic [63:0] y, output logic [3:0] f);
      logic [63:0]        ua, ub, s;
      logic signed [63:0] sa, sb, r;
      logic signed [64:0] w;
      logic [63:0]        cin;
      logic               c, v;
      ua  = {32'd0, a[31:0]};
      ub  = {32'd0, b[31:0]};
      sa  = {{32{a[31]}}, a[31:0]};
      sb  = {{32{b[31]}}, b[31:0]};
      cin = (cmd == 4'd2 || cmd == 4'd3) ? {63'd0, fq[1]} : 64'd0;
      y = 64'd0; c = 1'b0; v = 1'b0;
      case (cmd)
         4'd0, 4'd2: begin
            s = ua + ub + cin;
            y = {32'd0, s[31:0]};
            c = s[32];
            r = sa + sb + $signed(cin);
            v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
         end
         4'd1, 4'd3: begin
            s = ua - ub - cin;
            y = {32'd0, s[31:0]};
            c = ua < (ub + cin);
            r = sa - sb - $signed(cin);
            v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
         end
         4'd4: begin y = ua & ub; c = fq[1]; v = fq[0]; end
         4'd5: begin y = ua | ub; c = fq[1]; v = fq[0]; end
         4'd6: begin y = ua ^ ub; c = fq[1]; v = fq[0]; end
         4'd7: begin
            y = a + b;
            c = ({1'b0, a} + {1'b0, b}) > 65'h0_FFFF_FFFF_FFFF_FFFF;
            w = $signed({a[63], a}) + $signed({b[63], b});
            v = w[64] != w[63];
         end
         4'd8: begin
            y = a - b;
            c = a < b;
            w = $signed({a[63], a}) - $signed({b[63], b});
            v = w[64] != w[63];
         end
         default: ;
      endcase
      if (cmd > 4'd8) f = 4'b0000;
      else f = {(cmd >= 4'd7) ? y[63] : y[31], y == 64'd0, c, v};
   endfunction

   task automatic start_req(input logic [3:0] cmd, input logic [63:0] a, input logic [63:0] b,
                            input logic sf, input logic [3:0] tag);
      req_valid = 1'b1; req_cmd = cmd; req_a = a; req_b = b;
      req_setflags = sf; req_tag = tag;
   endtask

   task automatic run_cmd(input logic [3:0] cmd, input logic [63:0] a, input logic [63:0] b,
                          input logic sf, input logic [3:0] tag);
      logic [63:0] ey;
      logic [3:0]  ef;
      int          lat, exp_lat;
      logic        ill;
      ref_model(cmd, a, b, exp_fq, ey, ef);
      ill     = cmd > 4'd8;
      exp_lat = ill ? 1 : (cmd >= 4'd7 ? 3 : 2);
      if (sf && !ill) begin
         if (cmd >= 4'd4 && cmd <= 4'd6) exp_fq[3:2] = ef[3:2];
         else exp_fq = ef;
      end
      start_req(cmd, a, b, sf, tag);
      rsp_ready = 1'b0;
      chk("req_ready_idle", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
      chk($sformatf("latency cmd%0d", cmd), 64'(lat), 64'(exp_lat));
      chk($sformatf("y cmd%0d", cmd), rsp_y, ey);
      if (!ill) chk($sformatf("flags cmd%0d", cmd), 64'(rsp_flags), 64'(ef));
      chk("tag", 64'(rsp_tag), 64'(tag));
      chk("illegal", 64'(rsp_illegal), 64'(ill));
      chk("flags_q", 64'(flags_q), 64'(exp_fq));
      last_y = rsp_y;
      last_f = rsp_flags;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("idle_after_rsp", 64'({req_ready, rsp_valid}), 64'b10);
   endtask

   initial begin
      logic [63:0] hold_y;
      logic [3:0]  hold_f, ef;
      logic [63:0] ey;
      reset_n = 1'b0; req_valid = 1'b0; req_cmd = '0; req_a = '0; req_b = '0;
      req_setflags = 1'b0; req_tag = '0; rsp_ready = 1'b0; exp_fq = 4'b0000;
      last_y = '0; last_f = '0;
      #12;
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_rsp", {rsp_valid, rsp_illegal, rsp_tag, rsp_flags, 54'd0}, 64'd0);
      chk("rst_rsp_y", rsp_y, 64'd0);
      chk("rst_flags_q", 64'(flags_q), 64'd0);
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;

      run_cmd(4'd0, 64'h7FFF_FFFF, 64'h1, 1'b1, 4'h1);
      chk("add_ovf_y", last_y, 64'h8000_0000);
      chk("add_ovf_flags", 64'(last_f), 64'b1001);

      run_cmd(4'd0, 64'hFFFF_FFFF, 64'h1, 1'b1, 4'h2);
      chk("add_wrap_flags", 64'(last_f), 64'b0110);
      run_cmd(4'd2, 64'h0, 64'h0, 1'b0, 4'h3);
      chk("adc_y", last_y, 64'd1);
      chk("adc_fq_kept", 64'(flags_q), 64'b0110);

      run_cmd(4'd7, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 4'hA);
      chk("add64_y", last_y, 64'h0000_0001_0000_0000);
      run_cmd(4'd8, 64'h0000_0001_0000_0000, 64'h1, 1'b0, 4'hB);
      chk("sub64_y", last_y, 64'h0000_0000_FFFF_FFFF);
      run_cmd(4'd8, 64'h5, 64'h5, 1'b1, 4'hC);
      chk("sub64_zero_flags", 64'(last_f), 64'b0100);

      // Response back-pressure: AND held for 5 cycles while a second request waits.
      ref_model(4'd4, 64'hF0F0_1234, 64'hFF00_FF00, exp_fq, ey, ef);
      exp_fq[3:2] = ef[3:2];
      start_req(4'd4, 64'hF0F0_1234, 64'hFF00_FF00, 1'b1, 4'h5);
      @(posedge clk); #1;
      start_req(4'd5, 64'h1, 64'h2, 1'b0, 4'h6);
      @(posedge clk); #1;
      chk("and_valid", 64'(rsp_valid), 64'd1);
      hold_y = rsp_y; hold_f = rsp_flags;
      chk("and_y", hold_y, ey);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("hold_stable", {rsp_y[59:0], rsp_flags}, {hold_y[59:0], hold_f});
         chk("hold_blocked", 64'({req_ready, rsp_valid, rsp_tag}), 64'b1_0101);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      run_cmd(4'd5, 64'h1, 64'h2, 1'b0, 4'h6);
      chk("orr_y", last_y, 64'h3);

      run_cmd(4'd12, 64'h1234, 64'h5678, 1'b1, 4'h7);

      // Reset during the high pass of ADD64 must drop the command.
      start_req(4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 4'h9);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      exp_fq = 4'b0000;
      chk("midrst_ready", 64'({req_ready, rsp_valid, rsp_illegal}), 64'b100);
      chk("midrst_rsp", {rsp_y[55:0], rsp_flags, rsp_tag}, 64'd0);
      chk("midrst_flags_q", 64'(flags_q), 64'd0);
      @(negedge clk); reset_n = 1'b1;
      for (int i = 0; i < 4; i++) @(posedge clk);
      #1;
      chk("midrst_no_rsp", 64'({req_ready, rsp_valid}), 64'b10);

      for (int i = 0; i < 30; i++) begin
         logic [3:0] c;
         logic [63:0] a, b;
         c = 4'($urandom_range(0, 10));
         a = {$urandom, $urandom};
         b = (i % 5 == 0) ? a : {$urandom, $urandom};
         run_cmd(c, a, b, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencer and condition-flag owner for the 32-bit `ALU` datapath. It accepts commands over a valid/ready handshake and drives the ALU opcode, operands and carry-in. It chains two ALU passes for 64-bit add/subtract and keeps an architectural NZCV register that ADC/SBC read and S-suffixed commands write. It sits between the execute-stage issue logic and the ALU, which it instantiates.

## Interface
- `TAG_W`, default 4: width of the opaque tag carried from request to response.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  command present.
- `req_ready`  out  1  controller can accept a command.
- `req_cmd`  in  4  0 ADD, 1 SUB, 2 ADC, 3 SBC, 4 AND, 5 ORR, 6 EOR, 7 ADD64, 8 SUB64; 9–15 are illegal.
- `req_a`, `req_b`  in  64  operands; 32-bit commands use bits [31:0].
- `req_setflags`  in  1  update NZCV on completion.
- `req_tag`  in  TAG_W  returned unchanged.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_y`  out  64  result; for 32-bit commands, bits [63:32] are 0.
- `rsp_flags`  out  4  {N,Z,C,V} computed for this command, whether or not it was committed.
- `rsp_tag`  out  TAG_W  tag of the completed command.
- `rsp_illegal`  out  1  command was illegal; `rsp_y` is 0 and the flags are not updated.
- `flags_q`  out  4  architectural {N,Z,C,V}.

## Operation
- FSM states: IDLE, EXEC_LO, EXEC_HI, RESP.
  - `req_ready` = (state == IDLE).
  - A handshake latches the command, operands and tag, then moves to EXEC_LO.
- EXEC_LO drives ALU opcode, operand and Ci fields as follows:
  - ADD 0111, SUB 1000, ADC 1001, SBC 1010, AND 0001, ORR 0011, EOR 0101.
  - ADD64 drives 0111 and SUB64 drives 1000, both on the low words.
  - Ci = `flags_q`.C for ADC/SBC and 0 otherwise.
  - The ALU result is captured into the low result word and `lo_co`/`lo_z` are saved.
  - 32-bit commands then go to RESP; ADD64/SUB64 go to EXEC_HI.
- EXEC_HI drives the high words with ADC (1001) for ADD64 or SBC (1010) for SUB64, using Ci = `lo_co`.
  - C is a borrow for subtract, matching the ALU's SBC convention.
  - The high word is captured, then the FSM goes to RESP.
- ALU vectors are MSB-first ([0:31]). Connect them as whole vectors with no bit reversal.
- Flag formation:
  - N, C and V come from the last ALU pass.
  - Z comes from the pass for 32-bit commands and is `lo_z` & Z_hi for 64-bit commands.
  - Logical commands report C and V equal to the current `flags_q` values.
- Commit:
  - On entry to RESP, if `req_setflags` is set and the command is legal, `flags_q` ← `rsp_flags`.
  - Logical commands update only N and Z.
- Illegal command: goes IDLE → RESP directly with `rsp_illegal` = 1 and no ALU pass.
- RESP holds `rsp_*` stable while `rsp_ready` = 0. It returns to IDLE on `rsp_valid` & `rsp_ready`.

## Timing
- Reset, asynchronous: state IDLE, `req_ready` 1, `rsp_valid` 0, `rsp_y` 0, `rsp_flags` 0, `rsp_tag` 0, `rsp_illegal` 0, `flags_q` 0.
- Request handshake at edge 0 gives `rsp_valid` high after:
  - edge 2 for 32-bit commands;
  - edge 3 for 64-bit commands;
  - edge 1 for illegal commands.
- With `rsp_ready` = 1, the next request is accepted one cycle after the response handshake. Maximum throughput is 1 per 3 cycles (32-bit) or 1 per 4 cycles (64-bit).
- `flags_q` changes on the same edge that raises `rsp_valid`. A back-to-back ADC therefore sees the committed C.
- `rsp_*` and `flags_q` are registered. The ALU path is combinational within the EXEC cycle.
- Reset asserted in any state, including EXEC_HI, drops the in-flight command immediately; no response is produced.

## Structure
- Shared package `alu_pkg`:
  - command codes;
  - ALU opcode constants;
  - FSM state encoding;
  - flag bit indices N=3, Z=2, C=1, V=0.
- One sub-module: the existing `ALU`, instantiated as `u_alu`. The command-to-opcode decode is a local function.

## Test plan
- ADD, a=0x7FFFFFFF, b=0x1, setflags → `rsp_y`=0x80000000, flags N=1 Z=0 C=0 V=1, `rsp_valid` exactly 2 cycles after accept.
- ADD, a=0xFFFFFFFF, b=0x1, setflags → y=0, Z=1 C=1. Then ADC, a=0, b=0 → y=1 and `flags_q` unchanged (setflags=0).
- ADD64, a=0x00000000_FFFFFFFF, b=1 → y=0x00000001_00000000, Z=0 C=0, 3-cycle latency, tag echoed.
- SUB64, a=0x00000001_00000000, b=1 → y=0x00000000_FFFFFFFF, borrow chained; SUB64 with a=b=5 → y=0, Z=1.
- Hold `rsp_ready`=0 for 5 cycles after an AND → `rsp_*` stable, `req_ready`=0, second request not accepted. Release → next accept one cycle after handshake.
- Assert `reset_n` low during EXEC_HI of ADD64 → all outputs at reset values, no response. Also: `req_cmd`=12 → `rsp_illegal`=1 after 1 cycle, `flags_q` unchanged.
